// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants, FSM encoding and baud divider helper for the framed FIFO-to-UART transmitter.
package fifo_uart_tx_pkg;

  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;
  localparam int         BIT_CNT  = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_A,
    S_HDR_B,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_SEND,
    S_CHK
  } state_t;

  // Rounded clock cycles per serial bit.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_byte.sv
// 8N1 byte serializer: start bit one cycle after load, done pulses on the last stop-bit cycle.
module uart_byte_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DIV = 174
) (
  input  logic       clk_20M,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [3:0]    IDX_LAST  = 4'(BIT_CNT - 1);

  logic          r_busy;
  logic [CW-1:0] r_baud;
  logic [3:0]    r_idx;
  logic [8:0]    r_shift;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = r_busy && (r_baud == BAUD_LAST);
  assign done      = w_bit_end && (r_idx == IDX_LAST);
  assign tx        = r_tx;

  always_ff @(posedge clk_20M) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_baud <= '0;
      r_idx  <= '0;
      r_tx   <= 1'b1;
    end else if (!r_busy) begin
      if (load) begin
        r_busy <= 1'b1;
        r_baud <= '0;
        r_idx  <= '0;
        r_tx   <= 1'b0;
      end
    end else if (w_bit_end) begin
      r_baud <= '0;
      if (r_idx == IDX_LAST) begin
        r_busy <= 1'b0;
        r_tx   <= 1'b1;
      end else begin
        r_idx <= r_idx + 4'd1;
        r_tx  <= r_shift[0];
      end
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  // Remaining data bits with the stop bit behind them; pure datapath, no reset.
  always_ff @(posedge clk_20M) begin
    if (!r_busy && load) begin
      r_shift <= {1'b1, data};
    end else if (w_bit_end) begin
      r_shift <= {1'b1, r_shift[8:1]};
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Frame FSM draining fifo_2 into UART packets: AA 55, FRAME_LEN samples, 8-bit sum.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int         CLK_HZ    = 20000000,
  parameter int         BAUD      = 115200,
  parameter int         FRAME_LEN = 1024,
  parameter logic [7:0] HDR0      = HDR0_DEF,
  parameter logic [7:0] HDR1      = HDR1_DEF
) (
  input  logic       clk_20M,
  input  logic       rst,
  input  logic       fifo_2_empty,
  input  logic [7:0] fifo_2_q,
  output logic       fifo_2_rd,
  output logic       uart_tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int          DIV     = calc_div(CLK_HZ, BAUD);
  localparam logic [10:0] LEN_CNT = 11'(FRAME_LEN);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_count;
  logic [7:0]  r_sum;
  logic        r_issued;
  logic        r_frame_done;
  logic        w_load;
  logic        w_done;
  logic [7:0]  w_tx_data;

  uart_byte_tx #(.DIV(DIV)) u_byte_tx (
    .clk_20M (clk_20M),
    .rst     (rst),
    .load    (w_load),
    .data    (w_tx_data),
    .tx      (uart_tx),
    .done    (w_done)
  );

  always_ff @(posedge clk_20M) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_sum        <= '0;
      r_issued     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= (r_state == S_CHK) && w_done;
      // r_issued keeps header/checksum states from reloading while their byte is on the line.
      if (w_load) begin
        r_issued <= 1'b1;
      end else if (w_done) begin
        r_issued <= 1'b0;
      end
      if (r_state == S_IDLE) begin
        r_count <= '0;
        r_sum   <= '0;
      end else if (r_state == S_LOAD) begin
        r_count <= r_count + 11'd1;
        r_sum   <= r_sum + fifo_2_q;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_tx_data   = fifo_2_q;
    fifo_2_rd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_2_empty) w_state_nxt = S_HDR_A;
      end
      S_HDR_A: begin
        w_tx_data = HDR0;
        w_load    = !r_issued;
        if (w_done) w_state_nxt = S_HDR_B;
      end
      S_HDR_B: begin
        w_tx_data = HDR1;
        w_load    = !r_issued;
        if (w_done) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (!fifo_2_empty) begin
          fifo_2_rd   = !rst;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_done) w_state_nxt = (r_count == LEN_CNT) ? S_CHK : S_FETCH;
      end
      S_CHK: begin
        w_tx_data = r_sum;
        w_load    = !r_issued;
        if (w_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with FRAME_LEN=4 at the default 174-cycle bit period.
module tb_fifo_uart_tx;

  localparam int DIV      = 174;
  localparam int BYTE_CYC = 10 * DIV;
  localparam int HIST_N   = 100000;
  localparam int NS       = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  chk;
  } vec_t;

  logic       clk_20M      = 1'b0;
  logic       rst          = 1'b1;
  logic       fifo_2_empty = 1'b1;
  logic [7:0] fifo_2_q     = 8'h00;
  logic       fifo_2_rd;
  logic       uart_tx;
  logic       busy;
  logic       frame_done;

  fifo_uart_tx #(.CLK_HZ(20000000), .BAUD(115200), .FRAME_LEN(NS)) dut (
    .clk_20M      (clk_20M),
    .rst          (rst),
    .fifo_2_empty (fifo_2_empty),
    .fifo_2_q     (fifo_2_q),
    .fifo_2_rd    (fifo_2_rd),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk_20M = ~clk_20M;

  logic [7:0] fq[$];
  bit         hist_tx[HIST_N];
  bit         hist_busy[HIST_N];
  int         cyc    = 0;
  int         rd_cnt = 0;
  int         rd_bad = 0;
  int         rst_rd = 0;
  int         fd_cnt = 0;
  int         fd_cyc = 0;
  bit         rd_seen = 1'b0;
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         rx_n;
  logic [7:0] rx_b[16];
  int         rx_s[16];

  // Per-cycle record of the DUT outputs, taken mid-cycle.
  always @(negedge clk_20M) begin
    cyc = cyc + 1;
    if (cyc < HIST_N) begin
      hist_tx[cyc]   = uart_tx;
      hist_busy[cyc] = busy;
    end
    rd_seen = fifo_2_rd;
    if (fifo_2_rd) begin
      rd_cnt = rd_cnt + 1;
      if (fifo_2_empty) rd_bad = rd_bad + 1;
      if (rst) rst_rd = rst_rd + 1;
    end
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
  end

  // Normal (non-show-ahead) FIFO: data appears just after the edge that sampled the read.
  always @(posedge clk_20M) begin
    #1;
    if (rd_seen && fq.size() != 0) fifo_2_q = fq.pop_front();
    fifo_2_empty = (fq.size() == 0);
  end

  initial begin
    #950000;
    $display("watchdog expired at cycle %0d", cyc);
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic string nm(input int idx, input string s);
    return $sformatf("f%0d_%s", idx, s);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_20M);
    #1;
  endtask

  task automatic wait_fd(input int fd0, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk_20M);
      #1;
      if (fd_cnt > fd0) ok = 1'b1;
    end
  endtask

  task automatic wait_rd(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk_20M);
      #1;
      if (rd_cnt >= target) ok = 1'b1;
    end
  endtask

  // Recover bytes from the recorded line by mid-bit sampling.
  task automatic decode(input int a, input int b);
    int i;
    logic [7:0] v;
    rx_n = 0;
    for (int k = 0; k < 16; k++) begin
      rx_b[k] = 8'h00;
      rx_s[k] = -1;
    end
    i = (a < 1) ? 1 : a;
    while (i <= b && i + BYTE_CYC < HIST_N) begin
      if (!hist_tx[i] && hist_tx[i-1]) begin
        for (int k = 0; k < 8; k++) v[k] = hist_tx[i + DIV/2 + (k+1)*DIV];
        if (rx_n < 16) begin
          rx_b[rx_n] = v;
          rx_s[rx_n] = i;
          rx_n = rx_n + 1;
        end
        i = i + 9*DIV + DIV/2;
      end else begin
        i = i + 1;
      end
    end
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    int a, rd0, fd0, blen;
    bit ok;
    logic [7:0] exp_b[7];
    exp_b[0] = 8'hAA;
    exp_b[1] = 8'h55;
    for (int k = 0; k < NS; k++) exp_b[k+2] = v.data[8*k +: 8];
    exp_b[6] = v.chk;
    rd0 = rd_cnt;
    fd0 = fd_cnt;
    @(posedge clk_20M);
    #2;
    for (int k = 0; k < NS; k++) fq.push_back(v.data[8*k +: 8]);
    @(negedge clk_20M);
    #1;
    a = cyc;
    wait_fd(fd0, 14000, ok);
    check(nm(idx, "frame_done_seen"), int'(ok), 1);
    tick(2);
    decode(a, cyc);
    check(nm(idx, "byte_count"), rx_n, 7);
    for (int k = 0; k < 7; k++) check(nm(idx, $sformatf("byte%0d", k)), int'(rx_b[k]), int'(exp_b[k]));
    check(nm(idx, "rd_pulses"), rd_cnt - rd0, NS);
    check(nm(idx, "done_pulses"), fd_cnt - fd0, 1);
    check(nm(idx, "busy_before"), int'(hist_busy[a+1]), 0);
    check(nm(idx, "busy_rise"), int'(hist_busy[a+2]), 1);
    check(nm(idx, "hdr0_start"), rx_s[0], a + 3);
    check(nm(idx, "gap_hdr"), rx_s[1] - rx_s[0], BYTE_CYC + 1);
    check(nm(idx, "gap_sample"), rx_s[3] - rx_s[2], BYTE_CYC + 3);
    check(nm(idx, "gap_chk"), rx_s[6] - rx_s[5], BYTE_CYC + 1);
    check(nm(idx, "done_at_stop_end"), fd_cyc, rx_s[6] + BYTE_CYC);
    check(nm(idx, "busy_fall"), int'(hist_busy[fd_cyc]), 0);
    blen = 0;
    for (int i = a; i <= fd_cyc; i++) blen = blen + int'(hist_busy[i]);
    check(nm(idx, "busy_len"), blen, (NS + 3)*BYTE_CYC + 2 + 3*NS + 1);
  endtask

  initial begin
    vec_t       vecs[2];
    int         a, b, z, rd0, fd0, errs, s, c0, rdr;
    bit         ok;
    logic [9:0] pat;
    logic [7:0] uf_exp[7];

    vecs[0] = '{data: 32'h04030201, chk: 8'h0A};
    vecs[1] = '{data: 32'h0003FFFF, chk: 8'h01};

    rst = 1'b1;
    repeat (3) @(posedge clk_20M);
    @(negedge clk_20M);
    #1;
    check("reset_tx", int'(uart_tx), 1);
    check("reset_rd", int'(fifo_2_rd), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_done", int'(frame_done), 0);
    @(posedge clk_20M);
    #2;
    rst = 1'b0;

    // Long idle with an empty FIFO.
    @(negedge clk_20M);
    #1;
    a = cyc;
    tick(10000);
    z = 0;
    b = 0;
    for (int i = a; i <= cyc; i++) begin
      if (!hist_tx[i]) z = z + 1;
      if (hist_busy[i]) b = b + 1;
    end
    check("idle_line_low_cycles", z, 0);
    check("idle_busy_cycles", b, 0);
    check("idle_rd_pulses", rd_cnt, 0);

    for (int i = 0; i < 2; i++) run_frame(i, vecs[i]);

    // Underflow after the second sample, then resume.
    rd0 = rd_cnt;
    fd0 = fd_cnt;
    @(posedge clk_20M);
    #2;
    fq.push_back(8'h5A);
    fq.push_back(8'h11);
    @(negedge clk_20M);
    #1;
    a = cyc;
    wait_rd(rd0 + 2, 8000, ok);
    check("uf_two_reads_seen", int'(ok), 1);
    tick(2000);
    b = cyc;
    tick(3000);
    z = 0;
    for (int i = b; i <= cyc; i++) if (!hist_tx[i]) z = z + 1;
    check("uf_line_low_cycles", z, 0);
    check("uf_rd_while_stalled", rd_cnt - rd0, 2);
    check("uf_busy_held", int'(busy), 1);
    @(posedge clk_20M);
    #2;
    fq.push_back(8'h22);
    fq.push_back(8'h33);
    wait_fd(fd0, 8000, ok);
    check("uf_frame_done_seen", int'(ok), 1);
    tick(2);
    decode(a, cyc);
    uf_exp = '{8'hAA, 8'h55, 8'h5A, 8'h11, 8'h22, 8'h33, 8'hC0};
    check("uf_byte_count", rx_n, 7);
    for (int k = 0; k < 7; k++) check($sformatf("uf_byte%0d", k), int'(rx_b[k]), int'(uf_exp[k]));
    check("uf_rd_pulses", rd_cnt - rd0, NS);

    // Bit-level shape of the 0x5A sample: start, LSB-first data, stop.
    pat  = 10'b1010110100;
    s    = rx_s[2];
    errs = 0;
    if (s < 1) errs = errs + 1;
    else begin
      if (!hist_tx[s-1]) errs = errs + 1;
      for (int k = 0; k < 10; k++) begin
        if (hist_tx[s + k*DIV] != pat[k]) errs = errs + 1;
        if (hist_tx[s + k*DIV + DIV - 1] != pat[k]) errs = errs + 1;
      end
    end
    check("bit_timing_5A_errors", errs, 0);

    // Reset in the middle of a data bit of the third sample.
    rd0 = rd_cnt;
    @(posedge clk_20M);
    #2;
    fq.push_back(8'h01);
    fq.push_back(8'h02);
    fq.push_back(8'h00);
    fq.push_back(8'h04);
    wait_rd(rd0 + 3, 12000, ok);
    check("rst_third_read_seen", int'(ok), 1);
    tick(400);
    check("rst_line_low_before", int'(uart_tx), 0);
    @(posedge clk_20M);
    #2;
    rst = 1'b1;
    @(negedge clk_20M);
    @(negedge clk_20M);
    #1;
    check("rst_line_high", int'(uart_tx), 1);
    check("rst_busy_low", int'(busy), 0);
    rdr = rd_cnt;
    tick(3);
    check("rst_no_reads", rd_cnt - rdr, 0);
    @(posedge clk_20M);
    #2;
    rst = 1'b0;
    @(negedge clk_20M);
    #1;
    c0 = cyc;
    tick(2100);
    decode(c0, c0 + 1800);
    check("rst_fresh_hdr0", int'(rx_b[0]), 8'hAA);
    check("rst_fresh_start", rx_s[0], c0 + 2);
    check("rst_busy_before", int'(hist_busy[c0]), 0);
    check("rst_busy_rise", int'(hist_busy[c0+1]), 1);

    check("rd_while_empty", rd_bad, 0);
    check("rd_during_reset", rst_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drains the 8-bit sample stream from the output FIFO (fifo_2) and transmits it over the UART in framed packets. Each frame is a two-byte header, FRAME_LEN sample bytes and an 8-bit checksum. It is the consumer end of the capture path and replaces the free-running "read whenever non-empty" strobe with a read paced to the serial line.

## Interface
- CLK_HZ, 20000000, system clock frequency
- BAUD, 115200, serial bit rate
- FRAME_LEN, 1024, sample bytes per frame (1..2047)
- HDR0 / HDR1, 8'hAA / 8'h55, header bytes, sent in that order
- clk_20M  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fifo_2_empty  in  1  output FIFO empty flag
- fifo_2_q  in  8  output FIFO read data; valid the cycle after fifo_2_rd (normal, non-show-ahead FIFO)
- fifo_2_rd  out  1  read strobe; single-cycle pulse per sample
- uart_tx  out  1  serial line, idle high
- busy  out  1  high from frame start until the checksum stop bit ends
- frame_done  out  1  one-cycle pulse after the checksum stop bit

## Operation
- DIV = round(CLK_HZ/BAUD) = 174 at defaults, computed as (CLK_HZ + BAUD/2)/BAUD.
- Byte format: 1 start (0), 8 data LSB first, 1 stop (1). Each bit lasts DIV cycles, so one byte is 10*DIV cycles.
- FSM states and transitions:
  - IDLE: go to HDR_A when fifo_2_empty==0.
  - HDR_A: send HDR0, then go to HDR_B.
  - HDR_B: send HDR1, then go to FETCH.
  - FETCH: if fifo_2_empty==0, pulse fifo_2_rd and go to WAIT; otherwise stay in FETCH. The line is held high while waiting, with no timeout.
  - WAIT: one cycle for data to become valid, then go to LOAD.
  - LOAD: capture fifo_2_q into the serializer, add it to the checksum, increment the sample count, then go to SEND.
  - SEND: when the byte finishes, go to CHK if count==FRAME_LEN, else go to FETCH.
  - CHK: send the checksum, then go to IDLE with a frame_done pulse.
- Checksum: 8-bit sum of the sample bytes, mod 256. Header bytes are excluded. It clears in IDLE.
- Sample counter: 11 bits, clears in IDLE. The counter never wraps because FRAME_LEN ≤ 2047.
- fifo_2_rd is never asserted while fifo_2_empty==1 and never more than once per sample byte. Exactly FRAME_LEN reads occur per frame.

## Timing
- Reset values: uart_tx=1, fifo_2_rd=0, busy=0, frame_done=0, FSM=IDLE, counters=0.
- rst asserted mid-byte: uart_tx is 1 on the next edge and the partial byte is abandoned. No FIFO read occurs during reset.
- The serializer's start bit drives the line the cycle after its load strobe.
- Header bytes and checksum: 1 idle-high cycle before each start bit.
- Sample bytes with a non-empty FIFO:
  - The stop-bit end coincides with the FETCH cycle, which carries fifo_2_rd.
  - WAIT and LOAD follow.
  - The start bit begins 3 cycles after the previous stop bit ends.
- From IDLE with FIFO non-empty at cycle t: busy=1 at t+1 and the HDR0 start bit begins at t+2.
- Minimum frame length with no stalls: (FRAME_LEN+3)*10*DIV + 2 + 3*FRAME_LEN + 1 cycles.
- fifo_2_empty rising during WAIT/LOAD does not affect the byte in flight, because the read was already committed.

## Structure
- Shared package holds:
  - the header constants HDR0/HDR1
  - the FSM state encoding
  - the DIV computation function
  - the bit-count constant (10)
- One sub-module, uart_byte_tx:
  - ports: clk_20M, rst, load, data[7:0], tx, done
  - contents: a baud counter and a 4-bit bit index
  - done is a one-cycle pulse at the last cycle of the stop bit
  - load is ignored while busy
- The top level holds the frame FSM, the sample counter and the checksum accumulator.

## Test plan
- Reset then idle with fifo_2_empty=1 for 10000 cycles -> uart_tx stays 1, fifo_2_rd never asserts, busy=0.
- FRAME_LEN=4, FIFO preloaded with 01,02,03,04 -> line decodes AA 55 01 02 03 04 0A; exactly 4 fifo_2_rd pulses; one frame_done pulse; busy falls with it.
- Bit timing at DIV=174, byte 8'h5A -> each bit is 174 cycles wide and the pattern reads 0,0,1,0,1,1,0,1,0,1 (start, data LSB first, stop).
- Checksum wrap, FRAME_LEN=3, data FF,FF,03 -> checksum byte 8'h01.
- FIFO underflow: empty asserted after the 2nd sample of 4 for 5000 cycles -> line held high, no fifo_2_rd while empty; frame resumes correctly and the checksum matches.
- rst pulsed mid-data-bit of the 3rd sample -> uart_tx=1 the next cycle; after release with FIFO non-empty, a fresh frame starts with HDR0.
